ixc_nba_en_tracker: RTL and testbench



---
 rtl/ixc_nba_en_tracker.sv | 108 ++++++++++
 tb/tb_ixc_nba_en_tracker.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ixc_nba_en_tracker.sv
// Multi-channel NBA enable hold/delay tracker with drive-on strobes and a timestamped event FIFO.
// Strobe is 1 cycle after capture; FIFO is fall-through, full pushes are dropped and flag ovf.
module ixc_nba_en_tracker #(
  parameter int N_CH       = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int TS_W       = 16,
  parameter int EDGE_MODE  = 0
) (
  input  logic                          fclk,
  input  logic                          rst,
  input  logic                          bp_wait,
  input  logic [N_CH-1:0]               en,
  output logic [N_CH-1:0]               dr_on,
  output logic [N_CH-1:0]               en_nxt,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [N_CH-1:0]               ev_mask,
  output logic [TS_W-1:0]               ev_ts,
  output logic [$clog2(FIFO_DEPTH):0]   ev_count,
  output logic                          ovf,
  input  logic                          ovf_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [N_CH-1:0] mask;
    logic [TS_W-1:0] ts;
  } ev_t;

  logic [N_CH-1:0] en_l_q, en_l_d;
  logic [N_CH-1:0] en_d_q, en_d_d;
  logic [TS_W-1:0] ts_q, ts_d;
  logic [AW:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]     rd_ptr_q, rd_ptr_d;
  logic            ovf_q, ovf_d;
  ev_t             mem_q [FIFO_DEPTH];
  ev_t             mem_d [FIFO_DEPTH];

  logic [AW:0]     cnt;
  logic            full, empty, push_req, push, pop, drop;

  always_comb begin
    en_l_d = bp_wait ? en_l_q : en;
    en_d_d = en_l_q;
    ts_d   = bp_wait ? ts_q : ts_q + TS_W'(1);
    en_nxt = ~en_l_q;
    case (EDGE_MODE)
      1:       dr_on = en_l_q & ~en_d_q;
      2:       dr_on = ~en_l_q & en_d_q;
      default: dr_on = en_l_q ^ en_d_q;
    endcase
  end

  // Pointers carry one extra bit so full and empty differ at equal indices.
  always_comb begin
    cnt      = wr_ptr_q - rd_ptr_q;
    full     = (cnt == (AW+1)'(FIFO_DEPTH));
    empty    = (cnt == '0);
    push_req = |dr_on;
    pop      = ~empty & ev_ready;
    push     = push_req & (~full | pop);
    drop     = push_req & full & ~pop;
    wr_ptr_d = push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
    ovf_d    = drop | (ovf_q & ~ovf_clr);
    mem_d    = mem_q;
    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = '{mask: dr_on, ts: ts_q};
    end
  end

  always_comb begin
    ev_valid = ~empty;
    ev_count = cnt;
    ovf      = ovf_q;
    ev_mask  = '0;
    ev_ts    = '0;
    if (!empty) begin
      ev_mask = mem_q[rd_ptr_q[AW-1:0]].mask;
      ev_ts   = mem_q[rd_ptr_q[AW-1:0]].ts;
    end
  end

  always_ff @(posedge fclk) begin
    if (rst) begin
      en_l_q   <= '0;
      en_d_q   <= '0;
      ts_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      en_l_q   <= en_l_d;
      en_d_q   <= en_d_d;
      ts_q     <= ts_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge fclk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_ixc_nba_en_tracker.sv
// Bench for ixc_nba_en_tracker: scoreboard of expected FIFO events checked at pop time,
// plus directed checks on strobes, counts, overflow, edge modes and timestamp wrap.
module tb_ixc_nba_en_tracker;

  logic fclk = 1'b0;
  always #5 fclk = ~fclk;

  // main instance
  logic        rst, bp_wait, ev_ready, ovf_clr;
  logic [7:0]  en, dr_on, en_nxt, ev_mask;
  logic [15:0] ev_ts;
  logic [2:0]  ev_count;
  logic        ev_valid, ovf;

  // edge-mode instances share rst
  logic        e_bp, e_rdy, e_clr;
  logic [7:0]  en_e, r_dr_on, r_en_nxt, r_mask, f_dr_on, f_en_nxt, f_mask;
  logic [15:0] r_ts, f_ts;
  logic [2:0]  r_cnt, f_cnt;
  logic        r_vld, r_ovf, f_vld, f_ovf;

  // narrow-timestamp instance
  logic        rst_w, bp_w, rdy_w, clr_w;
  logic [7:0]  en_w, w_dr_on, w_en_nxt, w_mask;
  logic [3:0]  w_ts;
  logic [2:0]  w_cnt;
  logic        w_vld, w_ovf;

  ixc_nba_en_tracker #(.N_CH(8), .FIFO_DEPTH(4), .TS_W(16), .EDGE_MODE(0)) dut (
    .fclk(fclk), .rst(rst), .bp_wait(bp_wait), .en(en), .dr_on(dr_on), .en_nxt(en_nxt),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_mask(ev_mask), .ev_ts(ev_ts),
    .ev_count(ev_count), .ovf(ovf), .ovf_clr(ovf_clr));

  ixc_nba_en_tracker #(.N_CH(8), .FIFO_DEPTH(4), .TS_W(16), .EDGE_MODE(1)) dut_r (
    .fclk(fclk), .rst(rst), .bp_wait(e_bp), .en(en_e), .dr_on(r_dr_on), .en_nxt(r_en_nxt),
    .ev_valid(r_vld), .ev_ready(e_rdy), .ev_mask(r_mask), .ev_ts(r_ts),
    .ev_count(r_cnt), .ovf(r_ovf), .ovf_clr(e_clr));

  ixc_nba_en_tracker #(.N_CH(8), .FIFO_DEPTH(4), .TS_W(16), .EDGE_MODE(2)) dut_f (
    .fclk(fclk), .rst(rst), .bp_wait(e_bp), .en(en_e), .dr_on(f_dr_on), .en_nxt(f_en_nxt),
    .ev_valid(f_vld), .ev_ready(e_rdy), .ev_mask(f_mask), .ev_ts(f_ts),
    .ev_count(f_cnt), .ovf(f_ovf), .ovf_clr(e_clr));

  ixc_nba_en_tracker #(.N_CH(8), .FIFO_DEPTH(4), .TS_W(4), .EDGE_MODE(0)) dut_w (
    .fclk(fclk), .rst(rst_w), .bp_wait(bp_w), .en(en_w), .dr_on(w_dr_on), .en_nxt(w_en_nxt),
    .ev_valid(w_vld), .ev_ready(rdy_w), .ev_mask(w_mask), .ev_ts(w_ts),
    .ev_count(w_cnt), .ovf(w_ovf), .ovf_clr(clr_w));

  typedef struct packed {
    logic [7:0]  m;
    logic [15:0] t;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge fclk);
    #1;
  endtask

  task automatic expect_ev(input logic [7:0] m, input logic [15:0] t);
    exp_t e;
    e.m = m;
    e.t = t;
    sb_q.push_back(e);
  endtask

  // Monitor: every accepted head must match the oldest expected event.
  always @(negedge fclk) begin
    if (!rst && ev_valid && ev_ready) begin
      if (sb_q.size() == 0) begin
        check("pop_unexpected", 64'(sb_q.size()), 64'd1);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("pop_entry", {ev_mask, ev_ts}, {e.m, e.t});
      end
    end
  end

  initial begin
    logic [7:0] ovf_seq [5];
    ovf_seq[0] = 8'h1E; ovf_seq[1] = 8'h1C; ovf_seq[2] = 8'h18;
    ovf_seq[3] = 8'h10; ovf_seq[4] = 8'h00;

    rst = 1'b1; bp_wait = 1'b0; en = 8'h00; ev_ready = 1'b0; ovf_clr = 1'b0;
    e_bp = 1'b0; e_rdy = 1'b1; e_clr = 1'b0; en_e = 8'h00;
    rst_w = 1'b1; bp_w = 1'b0; rdy_w = 1'b0; clr_w = 1'b0; en_w = 8'h00;
    tick(); tick();
    check("rst_dr_on",  dr_on,    8'h00);
    check("rst_en_nxt", en_nxt,   8'hFF);
    check("rst_valid",  ev_valid, 1'b0);
    check("rst_count",  ev_count, 3'd0);
    check("rst_ovf",    ovf,      1'b0);
    check("rst_head",   {ev_mask, ev_ts}, 24'h0);

    // single change: ts counts 0,1,2 then the strobe cycle carries ts=3
    rst = 1'b0;
    tick(); tick();
    en = 8'h05;
    tick();
    check("single_dr_on",  dr_on,  8'h05);
    check("single_en_nxt", en_nxt, 8'hFA);
    expect_ev(8'h05, 16'd3);
    tick();
    check("single_pulse_end", dr_on, 8'h00);
    check("single_valid", ev_valid, 1'b1);
    check("single_count", ev_count, 3'd1);
    ev_ready = 1'b1; tick(); ev_ready = 1'b0;
    check("single_popped", ev_count, 3'd0);

    // freeze: ts holds at 5, en_l holds 05
    bp_wait = 1'b1;
    for (int i = 0; i < 10; i++) begin
      en = i[0] ? 8'h55 : 8'hAA;
      tick();
      check("freeze_dr_on",  dr_on,  8'h00);
      check("freeze_en_nxt", en_nxt, 8'hFA);
    end
    bp_wait = 1'b0; en = 8'h0F;
    tick();
    check("unfreeze_dr_on", dr_on, 8'h0A);
    expect_ev(8'h0A, 16'd6);
    tick();
    check("unfreeze_single", dr_on, 8'h00);
    ev_ready = 1'b1; tick(); ev_ready = 1'b0;
    check("unfreeze_popped", ev_count, 3'd0);

    // change captured just before bp_wait rises still strobes once (ts 8 -> 9)
    en = 8'h1F;
    tick();
    check("prebp_dr_on", dr_on, 8'h10);
    expect_ev(8'h10, 16'd9);
    bp_wait = 1'b1; en = 8'h00;
    tick();
    check("prebp_once", dr_on, 8'h00);
    tick();
    check("prebp_hold", dr_on, 8'h00);
    check("prebp_en_nxt", en_nxt, 8'hE0);
    bp_wait = 1'b0; en = 8'h1F;
    tick();
    check("prebp_resume", dr_on, 8'h00);
    ev_ready = 1'b1; tick(); ev_ready = 1'b0;
    check("prebp_popped", ev_count, 3'd0);

    // overflow: five strobes into a 4-deep FIFO, ts 12,14,16,18 kept, 20 dropped
    for (int k = 0; k < 5; k++) begin
      en = ovf_seq[k];
      tick();
      check("ovf_dr_on", dr_on, 8'(1 << k));
      if (k < 4) expect_ev(8'(1 << k), 16'(12 + 2 * k));
      tick();
      if (k == 3) begin
        check("ovf_count4", ev_count, 3'd4);
        check("ovf_not_yet", ovf, 1'b0);
      end
    end
    check("ovf_count_full", ev_count, 3'd4);
    check("ovf_set", ovf, 1'b1);
    check("ovf_head_kept", {ev_mask, ev_ts}, {8'h01, 16'd12});

    en = 8'h01;
    tick();
    expect_ev(8'h01, 16'd22);
    ev_ready = 1'b1; tick(); ev_ready = 1'b0;
    check("full_pushpop_count", ev_count, 3'd4);
    check("full_pushpop_ovf", ovf, 1'b1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    check("ovf_cleared", ovf, 1'b0);

    // clear coinciding with a drop: set wins
    en = 8'h00;
    tick();
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    check("ovf_set_wins", ovf, 1'b1);
    check("ovf_drop_count", ev_count, 3'd4);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    check("ovf_cleared2", ovf, 1'b0);

    ev_ready = 1'b1;
    repeat (4) tick();
    ev_ready = 1'b0;
    check("drain_count", ev_count, 3'd0);
    check("drain_valid", ev_valid, 1'b0);
    check("drain_head_zero", {ev_mask, ev_ts}, 24'h0);

    // edge qualification
    en_e = 8'h01; tick();
    check("rise_on_up",  r_dr_on, 8'h01);
    check("fall_on_up",  f_dr_on, 8'h00);
    en_e = 8'h00; tick();
    check("rise_on_dn",  r_dr_on, 8'h00);
    check("fall_on_dn",  f_dr_on, 8'h01);
    en_e = 8'h01; tick();
    check("rise_on_up2", r_dr_on, 8'h01);
    check("fall_on_up2", f_dr_on, 8'h00);
    tick();
    check("rise_idle",   r_dr_on, 8'h00);
    check("fall_idle",   f_dr_on, 8'h00);

    // 4-bit timestamp: strobe on the 17th unfrozen cycle carries ts=1
    rst_w = 1'b0;
    repeat (16) tick();
    en_w = 8'h01;
    tick();
    check("wrap_dr_on", w_dr_on, 8'h01);
    tick();
    check("wrap_valid", w_vld, 1'b1);
    check("wrap_head", {w_mask, w_ts}, {8'h01, 4'd1});
    en_w = 8'h03; tick();
    en_w = 8'h07; tick();
    tick();
    check("wrap_count3", w_cnt, 3'd3);
    en_w = 8'h0F; tick();
    rst_w = 1'b1; tick();
    check("midrst_count", w_cnt, 3'd0);
    check("midrst_valid", w_vld, 1'b0);
    check("midrst_head", {w_mask, w_ts}, 12'h0);
    check("midrst_dr_on", w_dr_on, 8'h00);
    rst_w = 1'b0; tick();
    check("midrst_inflight_gone", w_cnt, 3'd0);

    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
